pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Drives Stall/Flush of PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
//  Resolves cache-busy, divider-busy, load-use, exception and taken-branch events by fixed priority.
//  Tracks two multi-cycle conditions: a delay-slot fetch outstanding behind a taken branch, and an exception raised while a fetch is in flight.
//  Owns the PC redirect (valid + target) and a saturating stall-cycle counter.
// PARAMETERS
//  CNT_W    32            width of stall_cycles counter
//  EXC_VEC  32'hBFC00380  redirect target on exception (eret uses epc_i)
// PORTS
//  clk               in   1   clock, all state on rising edge
//  rst               in   1   asynchronous, active-high reset
//  ibus_busy         in   1   instruction fetch outstanding (Instruction not valid this cycle)
//  dbus_busy         in   1   MEM-stage data access outstanding
//  div_busy          in   1   EX-stage multicycle unit busy
//  load_use          in   1   ID instr depends on load in EX
//  branch_taken      in   1   ID resolves a taken branch/jump this cycle
//  branch_target     in   32  target for branch_taken
//  exc_valid         in   1   exception/eret committed in MEM this cycle
//  exc_is_eret       in   1   qualifies exc_valid: 1 = eret
//  epc_i             in   32  CP0 EPC
//  cnt_clr           in   1   synchronous clear of stall_cycles
//  PC_Stall          out  1   hold PC
//  IF_ID_Stall       out  1
//  IF_ID_Flush       out  1
//  ID_EX_Stall       out  1
//  ID_EX_Flush       out  1
//  EX_MEM_Stall      out  1
//  EX_MEM_Flush      out  1
//  MEM_WB_Flush      out  1
//  is_delayslot      out  1   instruction entering IF/ID this cycle is a delay slot
//  pc_redirect       out  1   PC loads pc_redirect_target next edge (overrides PC_Stall)
//  pc_redirect_target out 32
//  stall_cycles      out  CNT_W  saturating count of cycles with PC_Stall=1
// BEHAVIOUR
//  States: RUN, DS_WAIT, EXC_WAIT. Registers: state, tgt_q[31:0], stall_cycles. All control outputs combinational from state+inputs (0-cycle latency).
//  Reset: state=RUN, tgt_q=0, stall_cycles=0; while rst=1 every output is 0.
//  RUN priority (first match wins):
//   1 exc_valid: flush IF/ID, ID/EX, EX/MEM, MEM/WB. Target = exc_is_eret ? epc_i : EXC_VEC.
//     ibus_busy=0: pc_redirect=1 now, stay RUN. ibus_busy=1: PC_Stall=1, latch target into tgt_q, go EXC_WAIT.
//   2 dbus_busy: stall PC, IF/ID, ID/EX, EX/MEM; MEM_WB_Flush=1.
//   3 div_busy: stall PC, IF/ID, ID/EX; EX_MEM_Flush=1.
//   4 load_use: stall PC, IF/ID; ID_EX_Flush=1 (branch_taken ignored this cycle).
//   5 branch_taken: ibus_busy=0 -> is_delayslot=1, pc_redirect=1, target=branch_target.
//     ibus_busy=1 -> PC_Stall=1, IF_ID_Flush=1, latch branch_target into tgt_q, go DS_WAIT.
//   6 ibus_busy: PC_Stall=1, IF_ID_Flush=1 (bubble).
//   7 none: all 0.
//  DS_WAIT: exc_valid -> handled as RUN rule 1 (branch abandoned, tgt_q overwritten).
//   dbus_busy/div_busy -> stalls as rules 2/3; IF/ID also stalled; stay.
//   ibus_busy=1 -> PC_Stall=1, IF_ID_Flush=1; stay.
//   ibus_busy=0 -> is_delayslot=1, pc_redirect=1, target=tgt_q, go RUN.
//  EXC_WAIT: PC_Stall=1, IF_ID_Flush=1 every cycle (discard in-flight fetch).
//   ibus_busy=0 -> pc_redirect=1, target=tgt_q, go RUN. A new exc_valid here overwrites tgt_q, stays.
//  pc_redirect=1 forces PC_Stall=0 in the same cycle.
//  stall_cycles: +1 each cycle PC_Stall=1; saturates at all-ones; cnt_clr has priority over increment.
//  Async reset mid-DS_WAIT/EXC_WAIT: pending target is discarded; the fetch unit restarts from the reset vector.
// STRUCTURE
//  Shared package/header: state encodings (RUN=2'd0, DS_WAIT=2'd1, EXC_WAIT=2'd2), EXC_VEC default.
//  One natural sub-module: sat_counter (CNT_W, inc, clr) for stall_cycles. Next-state logic and output decode stay in this module.
// TESTING
//  exc_valid=1, exc_is_eret=0, ibus_busy=0 -> all four pipeline Flush=1, pc_redirect=1, target=32'hBFC00380, state stays RUN.
//  branch_taken=1 (target 32'h80001000) with ibus_busy=1 for 3 cycles -> PC_Stall=1/IF_ID_Flush=1 x3; then is_delayslot=1, pc_redirect=1, target=32'h80001000.
//  exc_valid=1 with ibus_busy=1 for 2 cycles -> IF_ID_Flush=1 for 2 cycles, redirect to EXC_VEC on the cycle ibus_busy falls.
//  dbus_busy=1, div_busy=1, load_use=1 together -> only rule 2: EX_MEM_Stall=1, MEM_WB_Flush=1, ID_EX_Flush=0, EX_MEM_Flush=0.
//  CNT_W=4: hold ibus_busy=1 for 20 cycles -> stall_cycles=15 (saturated); cnt_clr=1 -> 0 next edge.
//  rst asserted while in DS_WAIT -> outputs 0 immediately; after release, state RUN, no pc_redirect.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM state encoding
// and the default exception vector.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DS_WAIT  = 2'd1,
    EXC_WAIT = 2'd2
  } state_e;

  localparam logic [31:0] EXC_VEC_DEFAULT = 32'hBFC00380;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment and
// the count sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: resolves hazards by
// fixed priority, owns the PC redirect and counts PC stall cycles.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int          CNT_W   = 32,
  parameter logic [31:0] EXC_VEC = EXC_VEC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ibus_busy,
  input  logic             dbus_busy,
  input  logic             div_busy,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             exc_valid,
  input  logic             exc_is_eret,
  input  logic [31:0]      epc_i,
  input  logic             cnt_clr,
  output logic             PC_Stall,
  output logic             IF_ID_Stall,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Stall,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Stall,
  output logic             EX_MEM_Flush,
  output logic             MEM_WB_Flush,
  output logic             is_delayslot,
  output logic             pc_redirect,
  output logic [31:0]      pc_redirect_target,
  output logic [CNT_W-1:0] stall_cycles
);

  state_e      state_q, state_d;
  logic [31:0] tgt_q, tgt_d;

  logic        pc_stall_s, if_id_stall_s, if_id_flush_s, id_ex_stall_s, id_ex_flush_s;
  logic        ex_mem_stall_s, ex_mem_flush_s, mem_wb_flush_s, delayslot_s, redirect_s;
  logic [31:0] redirect_tgt_s, exc_tgt_s, ds_tgt_s;
  state_e      cur_s;

  // Next-state and control decode; outputs depend on state and inputs in the same cycle.
  always_comb begin
    state_d        = state_q;
    tgt_d          = tgt_q;
    pc_stall_s     = 1'b0;
    if_id_stall_s  = 1'b0;
    if_id_flush_s  = 1'b0;
    id_ex_stall_s  = 1'b0;
    id_ex_flush_s  = 1'b0;
    ex_mem_stall_s = 1'b0;
    ex_mem_flush_s = 1'b0;
    mem_wb_flush_s = 1'b0;
    delayslot_s    = 1'b0;
    redirect_s     = 1'b0;
    redirect_tgt_s = 32'h0000_0000;
    exc_tgt_s      = exc_is_eret ? epc_i : EXC_VEC;

    // An unreachable encoding is treated as RUN and steered back there.
    case (state_q)
      RUN:      cur_s = RUN;
      DS_WAIT:  cur_s = DS_WAIT;
      EXC_WAIT: cur_s = EXC_WAIT;
      default:  cur_s = RUN;
    endcase
    state_d  = cur_s;
    ds_tgt_s = (cur_s == DS_WAIT) ? tgt_q : branch_target;

    if (cur_s == EXC_WAIT) begin
      pc_stall_s    = 1'b1;
      if_id_flush_s = 1'b1;
      if (exc_valid) begin
        id_ex_flush_s  = 1'b1;
        ex_mem_flush_s = 1'b1;
        mem_wb_flush_s = 1'b1;
        tgt_d          = exc_tgt_s;
      end else if (!ibus_busy) begin
        redirect_s     = 1'b1;
        redirect_tgt_s = tgt_q;
        state_d        = RUN;
      end else begin
        state_d = EXC_WAIT;
      end
    end else if (exc_valid) begin
      if_id_flush_s  = 1'b1;
      id_ex_flush_s  = 1'b1;
      ex_mem_flush_s = 1'b1;
      mem_wb_flush_s = 1'b1;
      if (ibus_busy) begin
        pc_stall_s = 1'b1;
        tgt_d      = exc_tgt_s;
        state_d    = EXC_WAIT;
      end else begin
        redirect_s     = 1'b1;
        redirect_tgt_s = exc_tgt_s;
        state_d        = RUN;
      end
    end else if (dbus_busy) begin
      pc_stall_s     = 1'b1;
      if_id_stall_s  = 1'b1;
      id_ex_stall_s  = 1'b1;
      ex_mem_stall_s = 1'b1;
      mem_wb_flush_s = 1'b1;
    end else if (div_busy) begin
      pc_stall_s     = 1'b1;
      if_id_stall_s  = 1'b1;
      id_ex_stall_s  = 1'b1;
      ex_mem_flush_s = 1'b1;
    end else if (load_use && (cur_s == RUN)) begin
      pc_stall_s    = 1'b1;
      if_id_stall_s = 1'b1;
      id_ex_flush_s = 1'b1;
    end else if ((cur_s == DS_WAIT) || branch_taken) begin
      // The delay slot must be fetched before the branch target is loaded.
      if (ibus_busy) begin
        pc_stall_s    = 1'b1;
        if_id_flush_s = 1'b1;
        tgt_d         = ds_tgt_s;
        state_d       = DS_WAIT;
      end else begin
        delayslot_s    = 1'b1;
        redirect_s     = 1'b1;
        redirect_tgt_s = ds_tgt_s;
        state_d        = RUN;
      end
    end else if (ibus_busy) begin
      pc_stall_s    = 1'b1;
      if_id_flush_s = 1'b1;
    end else begin
      state_d = RUN;
    end

    if (redirect_s) begin
      pc_stall_s = 1'b0;
    end else begin
      pc_stall_s = pc_stall_s;
    end
  end

  // State and pending-target registers; reset drops any pending redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      tgt_q   <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  assign PC_Stall           = pc_stall_s     & ~rst;
  assign IF_ID_Stall        = if_id_stall_s  & ~rst;
  assign IF_ID_Flush        = if_id_flush_s  & ~rst;
  assign ID_EX_Stall        = id_ex_stall_s  & ~rst;
  assign ID_EX_Flush        = id_ex_flush_s  & ~rst;
  assign EX_MEM_Stall       = ex_mem_stall_s & ~rst;
  assign EX_MEM_Flush       = ex_mem_flush_s & ~rst;
  assign MEM_WB_Flush       = mem_wb_flush_s & ~rst;
  assign is_delayslot       = delayslot_s    & ~rst;
  assign pc_redirect        = redirect_s     & ~rst;
  assign pc_redirect_target = rst ? 32'h0000_0000 : redirect_tgt_s;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (PC_Stall),
    .clr_i (cnt_clr),
    .cnt_o (stall_cycles)
  );

endmodule
